// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter.
// Inhibits the clock, requests to send, then shifts a byte out on device clocks.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 10000,
  parameter int REQ_CYCLES     = 50,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic       CLOCK,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy,
  output logic       done,
  output logic       err,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_INHIBIT   = 3'd1;
  localparam logic [2:0] S_REQ       = 3'd2;
  localparam logic [2:0] S_SEND      = 3'd3;
  localparam logic [2:0] S_ACK_OK    = 3'd4;
  localparam logic [2:0] S_WAIT_IDLE = 3'd5;

  localparam int CMAX =
    (INHIBIT_CYCLES > REQ_CYCLES) ?
    INHIBIT_CYCLES : REQ_CYCLES;
  localparam int CW = $clog2(CMAX + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [CW-1:0] INH_LAST =
    CW'(INHIBIT_CYCLES - 1);
  localparam logic [CW-1:0] REQ_LAST =
    CW'(REQ_CYCLES - 1);
  localparam logic [CW-1:0] C_ONE = CW'(1);
  localparam logic [TW-1:0] TO_LAST =
    TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] TO_SAT =
    TW'(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] T_ONE = TW'(1);

  logic [2:0]    state;
  logic [CW-1:0] cnt;
  logic [TW-1:0] to_cnt;
  logic [3:0]    bit_cnt;
  logic [8:0]    shreg;
  logic          idle_seen;

  logic clk_meta, clk_sync, clk_last;
  logic data_meta, data_sync;
  logic fall;

  assign tx_ready = (state == S_IDLE);
  assign busy     = ~tx_ready;
  assign fall     = clk_last & ~clk_sync;

  // Two-flop synchronizers plus a history flop for edge detection.
  always_ff @(posedge CLOCK) begin
    if (reset) begin
      clk_meta  <= 1'b1;
      clk_sync  <= 1'b1;
      clk_last  <= 1'b1;
      data_meta <= 1'b1;
      data_sync <= 1'b1;
    end else begin
      clk_meta  <= ps2_clk_in;
      clk_sync  <= clk_meta;
      clk_last  <= clk_sync;
      data_meta <= ps2_data_in;
      data_sync <= data_meta;
    end
  end

  // Transfer sequencer: inhibit, request, shift bits, ack, line idle.
  always_ff @(posedge CLOCK) begin
    if (reset) begin
      state       <= S_IDLE;
      cnt         <= '0;
      to_cnt      <= '0;
      bit_cnt     <= '0;
      shreg       <= '0;
      idle_seen   <= 1'b0;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      if (state == S_IDLE)
        to_cnt <= '0;
      else if (to_cnt != TO_SAT)
        to_cnt <= to_cnt + T_ONE;
      case (state)
        S_IDLE: begin
          ps2_clk_oe  <= 1'b0;
          ps2_data_oe <= 1'b0;
          if (tx_valid) begin
            shreg      <= {~^tx_data, tx_data};
            cnt        <= '0;
            ps2_clk_oe <= 1'b1;
            state      <= S_INHIBIT;
          end
        end
        S_INHIBIT: begin
          if (cnt == INH_LAST) begin
            cnt         <= '0;
            ps2_data_oe <= 1'b1;
            state       <= S_REQ;
          end else begin
            cnt <= cnt + C_ONE;
          end
        end
        S_REQ: begin
          if (cnt == REQ_LAST) begin
            cnt        <= '0;
            bit_cnt    <= '0;
            to_cnt     <= '0;
            ps2_clk_oe <= 1'b0;
            state      <= S_SEND;
          end else begin
            cnt <= cnt + C_ONE;
          end
        end
        S_SEND: begin
          if (to_cnt == TO_LAST) begin
            ps2_data_oe <= 1'b0;
            err         <= 1'b1;
            state       <= S_IDLE;
          end else if (fall) begin
            bit_cnt <= bit_cnt + 4'd1;
            if (bit_cnt < 4'd9) begin
              ps2_data_oe <= ~shreg[0];
              shreg       <= {1'b0, shreg[8:1]};
            end else if (bit_cnt == 4'd9) begin
              ps2_data_oe <= 1'b0;
            end else begin
              idle_seen <= 1'b0;
              if (!data_sync) begin
                state <= S_ACK_OK;
              end else begin
                err   <= 1'b1;
                state <= S_WAIT_IDLE;
              end
            end
          end
        end
        S_ACK_OK: begin
          done      <= 1'b1;
          idle_seen <= 1'b0;
          state     <= S_WAIT_IDLE;
        end
        S_WAIT_IDLE: begin
          if (clk_sync && data_sync) begin
            idle_seen <= 1'b1;
            if (idle_seen)
              state <= S_IDLE;
          end else begin
            idle_seen <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
